fwd_hazard_ctrl: RTL and testbench

- Forwarding and hazard control stage for the 5-stage 16-bit pipeline.
- Tracks destination-register tags of instructions in EX, MEM and WB.
- Compares decode-stage source registers against those tags and produces registered 2-bit operand selects. The selects drive the EX-stage ALU operand 4:1 muxes.
- Detects load-use hazards, asserts a one-cycle stall and injects a bubble into EX.

---
 rtl/fwd_pkg.sv | 29 ++
 rtl/fwd_stage_reg.sv | 27 ++
 rtl/fwd_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard stage: operand-select codes,
// pipeline stage tag layout and the source-versus-producer match rule.
package fwd_pkg;

  localparam int TAG_RD_W = 3;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] FWD_IMM   = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                reg_wr;
    logic                mem_rd;
  } stage_tag_t;

  localparam int TAG_W = $bits(stage_tag_t);

  // r0 is hardwired zero, so a write to it never produces a forwardable value
  function automatic logic src_match(input logic                used,
                                     input logic [TAG_RD_W-1:0] src,
                                     input stage_tag_t          tag);
    return used & (src != {TAG_RD_W{1'b0}}) & tag.valid & tag.reg_wr &
           (tag.rd == src);
  endfunction

endpackage

// File: rtl/fwd_stage_reg.sv
// One pipeline stage tag register; a bubble loads an all-zero (invalid) tag.
module fwd_stage_reg
  import fwd_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bubble_i,
  input  logic [TAG_W-1:0] tag_d_i,
  output logic [TAG_W-1:0] tag_q_o
);

  logic [TAG_W-1:0] tag_q;

  // Tag storage with synchronous reset and bubble insertion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q <= {TAG_W{1'b0}};
    end else if (bubble_i) begin
      tag_q <= {TAG_W{1'b0}};
    end else begin
      tag_q <= tag_d_i;
    end
  end

  assign tag_q_o = tag_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control: tracks EX/MEM/WB destination tags,
// registers EX operand-mux selects and raises a one-cycle load-use stall.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = TAG_RD_W
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  id_use_imm,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_mem_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            ex_fwd_a_sel,
  output logic [1:0]            ex_fwd_b_sel,
  output logic                  ex_valid,
  output logic                  mem_valid,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_reg_wr
);

  stage_tag_t id_tag_s;
  stage_tag_t ex_tag_s;
  stage_tag_t mem_tag_s;
  stage_tag_t wb_tag_s;

  logic       rs1_ex_s;
  logic       rs2_ex_s;
  logic       rs1_mem_s;
  logic       rs2_mem_s;
  logic       stall_s;
  logic       bubble_s;
  logic [1:0] a_sel_d;
  logic [1:0] b_sel_d;
  logic [1:0] a_sel_q;
  logic [1:0] b_sel_q;

  assign id_tag_s.valid  = id_valid;
  assign id_tag_s.rd     = id_rd;
  assign id_tag_s.reg_wr = id_reg_wr;
  assign id_tag_s.mem_rd = id_mem_rd;

  fwd_stage_reg u_ex_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (bubble_s),
    .tag_d_i  (id_tag_s),
    .tag_q_o  (ex_tag_s)
  );

  fwd_stage_reg u_mem_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .tag_d_i  (ex_tag_s),
    .tag_q_o  (mem_tag_s)
  );

  fwd_stage_reg u_wb_tag (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .tag_d_i  (mem_tag_s),
    .tag_q_o  (wb_tag_s)
  );

  assign rs1_ex_s  = src_match(id_rs1_used, id_rs1, ex_tag_s);
  assign rs2_ex_s  = src_match(id_rs2_used, id_rs2, ex_tag_s);
  assign rs1_mem_s = src_match(id_rs1_used, id_rs1, mem_tag_s);
  assign rs2_mem_s = src_match(id_rs2_used, id_rs2, mem_tag_s);

  // Hazard detection and next operand selects; EX (youngest) producer wins
  always_comb begin
    stall_s  = id_valid & ex_tag_s.mem_rd & (rs1_ex_s | rs2_ex_s) & ~flush;
    bubble_s = stall_s | flush;
    a_sel_d  = FWD_RF;
    b_sel_d  = FWD_RF;

    if (rs1_ex_s) begin
      a_sel_d = ex_tag_s.mem_rd ? FWD_RF : FWD_EXMEM;
    end else if (rs1_mem_s) begin
      a_sel_d = FWD_MEMWB;
    end else begin
      a_sel_d = FWD_RF;
    end

    if (id_use_imm) begin
      b_sel_d = FWD_IMM;
    end else if (rs2_ex_s) begin
      b_sel_d = ex_tag_s.mem_rd ? FWD_RF : FWD_EXMEM;
    end else if (rs2_mem_s) begin
      b_sel_d = FWD_MEMWB;
    end else begin
      b_sel_d = FWD_RF;
    end

    // a load match in EX always stalls, so its FWD_RF above never reaches EX
    if (bubble_s || !id_valid) begin
      a_sel_d = FWD_RF;
      b_sel_d = FWD_RF;
    end else begin
      a_sel_d = a_sel_d;
      b_sel_d = b_sel_d;
    end
  end

  // Operand selects registered alongside the EX tag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sel_q <= FWD_RF;
      b_sel_q <= FWD_RF;
    end else begin
      a_sel_q <= a_sel_d;
      b_sel_q <= b_sel_d;
    end
  end

  assign stall        = stall_s;
  assign ex_fwd_a_sel = a_sel_q;
  assign ex_fwd_b_sel = b_sel_q;
  assign ex_valid     = ex_tag_s.valid;
  assign mem_valid    = mem_tag_s.valid;
  assign wb_valid     = wb_tag_s.valid;
  assign wb_rd        = wb_tag_s.rd;
  assign wb_reg_wr    = wb_tag_s.valid & wb_tag_s.reg_wr;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed and random bench for fwd_hazard_ctrl against an in-order
// instruction-history reference model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs1_used, id_rs2_used, id_use_imm;
  logic       id_reg_wr, id_mem_rd, flush;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       stall, ex_valid, mem_valid, wb_valid, wb_reg_wr;
  logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;
  logic [2:0] wb_rd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       v;
    bit [2:0] rd;
    bit       wr;
    bit       ld;
  } instr_t;

  // hist[0] = instruction in EX, hist[1] = MEM, hist[2] = WB
  instr_t   hist[3];
  bit [1:0] exp_a, exp_b;
  bit       sel_known;

  always #5 clk = ~clk;

  fwd_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_use_imm(id_use_imm), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_mem_rd(id_mem_rd), .flush(flush), .stall(stall),
    .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit produces(input instr_t t, input bit used, input bit [2:0] src);
    return used && src != 3'd0 && t.v && t.wr && t.rd == src;
  endfunction

  function automatic bit model_stall();
    bit dep;
    dep = produces(hist[0], id_rs1_used, id_rs1) || produces(hist[0], id_rs2_used, id_rs2);
    return id_valid && !flush && dep && hist[0].ld;
  endfunction

  // Search producers from youngest to oldest; WB needs no forwarding
  function automatic bit [1:0] want_sel(input bit used, input bit [2:0] src);
    if (produces(hist[0], used, src)) return hist[0].ld ? 2'd0 : 2'd1;
    if (produces(hist[1], used, src)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic check_regs();
    chk("ex_valid",  {7'd0, ex_valid},  {7'd0, hist[0].v});
    chk("mem_valid", {7'd0, mem_valid}, {7'd0, hist[1].v});
    chk("wb_valid",  {7'd0, wb_valid},  {7'd0, hist[2].v});
    chk("wb_rd",     {5'd0, wb_rd},     {5'd0, hist[2].rd});
    chk("wb_reg_wr", {7'd0, wb_reg_wr}, {7'd0, hist[2].v & hist[2].wr});
    if (sel_known) begin
      chk("a_sel", {6'd0, ex_fwd_a_sel}, {6'd0, exp_a});
      chk("b_sel", {6'd0, ex_fwd_b_sel}, {6'd0, exp_b});
    end
  endtask

  // One clock with the currently driven inputs; called just after a negedge
  task automatic step(input bit do_rst);
    bit       ms;
    bit [1:0] na, nb;
    instr_t   dec;
    #1;
    ms = model_stall();
    chk("stall", {7'd0, stall}, {7'd0, ms});
    na = id_use_imm ? 2'd3 : want_sel(id_rs1_used, id_rs1);
    na = want_sel(id_rs1_used, id_rs1);
    nb = id_use_imm ? 2'd3 : want_sel(id_rs2_used, id_rs2);
    dec = '{v: id_valid, rd: id_rd, wr: id_reg_wr, ld: id_mem_rd};
    rst_n = ~do_rst;
    @(posedge clk);
    if (do_rst) begin
      foreach (hist[i]) hist[i] = '{v: 0, rd: 0, wr: 0, ld: 0};
      exp_a = 2'd0; exp_b = 2'd0; sel_known = 1'b1;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      if (ms || flush) begin
        hist[0] = '{v: 0, rd: 0, wr: 0, ld: 0};
        exp_a = 2'd0; exp_b = 2'd0; sel_known = 1'b1;
      end else begin
        hist[0] = dec;
        exp_a = na; exp_b = nb; sel_known = id_valid;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_regs();
  endtask

  // Present one instruction and retry it while the model says it is stalled
  task automatic issue(input bit v, input bit [2:0] rs1, input bit [2:0] rs2,
                       input bit u1, input bit u2, input bit imm,
                       input bit [2:0] rd, input bit wr, input bit ld,
                       input bit fl, output int nstall);
    bit was;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1;
    id_rs2_used = u2; id_use_imm = imm; id_rd = rd; id_reg_wr = wr;
    id_mem_rd = ld; flush = fl;
    nstall = 0;
    for (int k = 0; k < 4; k++) begin
      was = model_stall();
      step(1'b0);
      if (!was) break;
      nstall++;
    end
  endtask

  task automatic nop();
    int n;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, n);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_use_imm = 0; id_rd = 0; id_reg_wr = 0; id_mem_rd = 0; flush = 0;
    foreach (hist[i]) hist[i] = '{v: 0, rd: 0, wr: 0, ld: 0};
    exp_a = 2'd0; exp_b = 2'd0; sel_known = 1'b1;
    @(posedge clk);
    @(negedge clk);
    step(1'b1);
    chk("rst_a_sel", {6'd0, ex_fwd_a_sel}, 8'd0);

    // distance 1 ALU forwarding on both operands
    issue(1, 2, 3, 1, 1, 0, 1, 1, 0, 0, n);
    issue(1, 1, 1, 1, 1, 0, 2, 1, 0, 0, n);
    chk("d1_nostall", n[7:0], 8'd0);
    chk("d1_a", {6'd0, ex_fwd_a_sel}, 8'd1);
    chk("d1_b", {6'd0, ex_fwd_b_sel}, 8'd1);

    // distance 2
    issue(1, 1, 2, 1, 1, 0, 3, 1, 0, 0, n);
    nop();
    issue(1, 3, 0, 1, 0, 0, 7, 1, 0, 0, n);
    chk("d2_a", {6'd0, ex_fwd_a_sel}, 8'd2);

    // youngest producer wins
    issue(1, 1, 2, 1, 1, 0, 4, 1, 0, 0, n);
    issue(1, 2, 3, 1, 1, 0, 4, 1, 0, 0, n);
    issue(1, 4, 0, 1, 0, 0, 1, 1, 0, 0, n);
    chk("young_a", {6'd0, ex_fwd_a_sel}, 8'd1);

    // load-use: one stall cycle, then MEM/WB forwarding
    issue(1, 1, 0, 1, 0, 1, 5, 1, 1, 0, n);
    issue(1, 5, 0, 1, 0, 0, 6, 1, 0, 0, n);
    chk("lu_stalls", n[7:0], 8'd1);
    chk("lu_a", {6'd0, ex_fwd_a_sel}, 8'd2);
    chk("lu_ex_valid", {7'd0, ex_valid}, 8'd1);
    chk("lu_wb_rd", {5'd0, wb_rd}, 8'd5);
    chk("lu_wb_wr", {7'd0, wb_reg_wr}, 8'd1);

    // r0, immediate and unused source
    issue(1, 1, 1, 1, 1, 0, 0, 1, 0, 0, n);
    issue(1, 0, 0, 1, 1, 0, 3, 1, 0, 0, n);
    chk("r0_a", {6'd0, ex_fwd_a_sel}, 8'd0);
    chk("r0_b", {6'd0, ex_fwd_b_sel}, 8'd0);
    issue(1, 3, 3, 1, 1, 1, 2, 1, 0, 0, n);
    chk("imm_b", {6'd0, ex_fwd_b_sel}, 8'd3);
    issue(1, 0, 2, 0, 0, 0, 1, 1, 0, 0, n);
    chk("unused_b", {6'd0, ex_fwd_b_sel}, 8'd0);

    // flush overrides a pending load-use stall
    issue(1, 1, 0, 1, 0, 1, 6, 1, 1, 0, n);
    issue(1, 6, 0, 1, 0, 0, 2, 1, 0, 1, n);
    chk("flush_nostall", n[7:0], 8'd0);
    chk("flush_bubble", {7'd0, ex_valid}, 8'd0);

    // reset with three valid tags in flight
    issue(1, 1, 2, 1, 1, 0, 1, 1, 0, 0, n);
    issue(1, 1, 2, 1, 1, 0, 2, 1, 0, 0, n);
    issue(1, 2, 1, 1, 1, 0, 3, 1, 0, 0, n);
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1; id_rd = 4; id_reg_wr = 1;
    step(1'b1);
    chk("mrst_valids", {5'd0, ex_valid, mem_valid, wb_valid}, 8'd0);
    chk("mrst_sel", {4'd0, ex_fwd_a_sel, ex_fwd_b_sel}, 8'd0);

    // random traffic, inputs held while the model reports a stall
    for (int i = 0; i < 400; i++) begin
      if (!model_stall()) begin
        id_valid    = ($urandom_range(0, 7) != 0);
        id_rs1      = 3'($urandom_range(0, 3));
        id_rs2      = 3'($urandom_range(0, 3));
        id_rs1_used = $urandom_range(0, 1);
        id_rs2_used = $urandom_range(0, 1);
        id_use_imm  = ($urandom_range(0, 3) == 0);
        id_rd       = 3'($urandom_range(0, 3));
        id_reg_wr   = ($urandom_range(0, 3) != 0);
        id_mem_rd   = ($urandom_range(0, 2) == 0);
      end
      flush = ($urandom_range(0, 7) == 0);
      step($urandom_range(0, 63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
